// File: rtl/writeback_queue_if.sv
// writeback_queue_if: push, drain, lookup and occupancy signals of the writeback queue
interface writeback_queue_if #(parameter int DATA_W = 8, parameter int ADDR_W = 2, parameter int DEPTH = 4);
   logic                     in_valid;
   logic                     in_ready;
   logic [ADDR_W-1:0]        in_reg;
   logic [DATA_W-1:0]        in_data;
   logic                     wb_hold;
   logic                     write_reg_en;
   logic [ADDR_W-1:0]        write_reg;
   logic [DATA_W-1:0]        write_data;
   logic [ADDR_W-1:0]        lookup_reg1;
   logic [ADDR_W-1:0]        lookup_reg2;
   logic                     pending1;
   logic                     pending2;
   logic [DATA_W-1:0]        fwd_data1;
   logic [DATA_W-1:0]        fwd_data2;
   logic [$clog2(DEPTH):0]   count;
   modport slave (
      input  in_valid, in_reg, in_data, wb_hold, lookup_reg1, lookup_reg2,
      output in_ready, write_reg_en, write_reg, write_data, pending1, pending2,
             fwd_data1, fwd_data2, count
   );
   modport master (
      output in_valid, in_reg, in_data, wb_hold, lookup_reg1, lookup_reg2,
      input  in_ready, write_reg_en, write_reg, write_data, pending1, pending2,
             fwd_data1, fwd_data2, count
   );
endinterface

// File: rtl/writeback_queue.sv
// writeback_queue: FIFO of pending register-file writes, drained one per cycle,
// with pending-write lookup and youngest-value forwarding for two read ports
module writeback_queue #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 2,
   parameter int DEPTH  = 4
) (
   input logic              clk,
   input logic              rst_n,
   writeback_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [ADDR_W-1:0] r_reg  [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_reg;
   logic [DATA_W-1:0] r_wr_data;
   logic              w_ready;
   logic              w_push;
   logic              w_pop;
   logic              w_p1;
   logic              w_p2;
   logic [DATA_W-1:0] w_f1;
   logic [DATA_W-1:0] w_f2;
   logic [PW-1:0]     w_idx;
   assign w_ready = r_count < CW'(DEPTH);
   assign w_push  = bus.in_valid && w_ready;
   assign w_pop   = r_count != '0 && !bus.wb_hold;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_reg[i]  <= '0;
            r_data[i] <= '0;
         end
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_wr_en   <= 1'b0;
         r_wr_reg  <= '0;
         r_wr_data <= '0;
      end else begin
         if (w_push) begin
            r_reg[r_wr_ptr]  <= bus.in_reg;
            r_data[r_wr_ptr] <= bus.in_data;
            r_wr_ptr         <= r_wr_ptr + PW'(1);
         end
         r_wr_en <= w_pop;
         if (w_pop) begin
            r_wr_reg  <= r_reg[r_rd_ptr];
            r_wr_data <= r_data[r_rd_ptr];
            r_rd_ptr  <= r_rd_ptr + PW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   // Scan oldest (write port) to youngest so the last match left standing is the newest value
   always_comb begin
      w_idx = '0;
      w_p1  = r_wr_en && r_wr_reg == bus.lookup_reg1;
      w_p2  = r_wr_en && r_wr_reg == bus.lookup_reg2;
      w_f1  = w_p1 ? r_wr_data : '0;
      w_f2  = w_p2 ? r_wr_data : '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_idx = r_rd_ptr + PW'(i);
         if (CW'(i) < r_count && r_reg[w_idx] == bus.lookup_reg1) begin
            w_p1 = 1'b1;
            w_f1 = r_data[w_idx];
         end
         if (CW'(i) < r_count && r_reg[w_idx] == bus.lookup_reg2) begin
            w_p2 = 1'b1;
            w_f2 = r_data[w_idx];
         end
      end
   end
   assign bus.in_ready     = w_ready;
   assign bus.write_reg_en = r_wr_en;
   assign bus.write_reg    = r_wr_reg;
   assign bus.write_data   = r_wr_data;
   assign bus.pending1     = w_p1;
   assign bus.pending2     = w_p2;
   assign bus.fwd_data1    = w_f1;
   assign bus.fwd_data2    = w_f2;
   assign bus.count        = r_count;
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed vector table plus hand-written streaming and reset sequences
module tb_writeback_queue;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   writeback_queue_if #(.DATA_W(8), .ADDR_W(2), .DEPTH(4)) bus ();
   writeback_queue #(.DATA_W(8), .ADDR_W(2), .DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   typedef struct {
      logic        v;
      logic [1:0]  r;
      logic [7:0]  d;
      logic        h;
      logic [1:0]  l1;
      logic [1:0]  l2;
      logic [32:0] exp;
   } vec_t;
   vec_t vecs[19];
   int tests = 0;
   int fails = 0;
   // {ready, en, reg, data, p1, p2, f1, f2, count}
   function automatic logic [32:0] pk(logic rdy, logic en, logic [1:0] wr, logic [7:0] wd,
                                      logic p1, logic p2, logic [7:0] f1, logic [7:0] f2, logic [2:0] c);
      return {rdy, en, wr, wd, p1, p2, f1, f2, c};
   endfunction
   function automatic logic [32:0] outs();
      return {bus.in_ready, bus.write_reg_en, bus.write_reg, bus.write_data, bus.pending1,
              bus.pending2, bus.fwd_data1, bus.fwd_data2, bus.count};
   endfunction
   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic drive(input logic v, input logic [1:0] r, input logic [7:0] d, input logic h,
                        input logic [1:0] l1, input logic [1:0] l2);
      bus.in_valid    = v;
      bus.in_reg      = r;
      bus.in_data     = d;
      bus.wb_hold     = h;
      bus.lookup_reg1 = l1;
      bus.lookup_reg2 = l2;
   endtask
   function automatic vec_t mk(logic v, logic [1:0] r, logic [7:0] d, logic h,
                               logic [1:0] l1, logic [1:0] l2, logic [32:0] exp);
      vec_t t;
      t.v = v; t.r = r; t.d = d; t.h = h; t.l1 = l1; t.l2 = l2; t.exp = exp;
      return t;
   endfunction
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
   initial begin
      int sent, got;
      logic acc;
      vecs[0]  = mk(1, 2, 8'h5A, 0, 2, 0, pk(1, 0, 0, 8'h00, 1, 0, 8'h5A, 8'h00, 1));
      vecs[1]  = mk(0, 0, 8'h00, 0, 2, 0, pk(1, 1, 2, 8'h5A, 1, 0, 8'h5A, 8'h00, 0));
      vecs[2]  = mk(0, 0, 8'h00, 0, 2, 0, pk(1, 0, 2, 8'h5A, 0, 0, 8'h00, 8'h00, 0));
      vecs[3]  = mk(1, 0, 8'h10, 1, 0, 3, pk(1, 0, 2, 8'h5A, 1, 0, 8'h10, 8'h00, 1));
      vecs[4]  = mk(1, 1, 8'h20, 1, 0, 3, pk(1, 0, 2, 8'h5A, 1, 0, 8'h10, 8'h00, 2));
      vecs[5]  = mk(1, 2, 8'h30, 1, 0, 3, pk(1, 0, 2, 8'h5A, 1, 0, 8'h10, 8'h00, 3));
      vecs[6]  = mk(1, 3, 8'h40, 1, 0, 3, pk(0, 0, 2, 8'h5A, 1, 1, 8'h10, 8'h40, 4));
      vecs[7]  = mk(1, 1, 8'hFF, 1, 0, 3, pk(0, 0, 2, 8'h5A, 1, 1, 8'h10, 8'h40, 4));
      vecs[8]  = mk(0, 0, 8'h00, 0, 1, 3, pk(1, 1, 0, 8'h10, 1, 1, 8'h20, 8'h40, 3));
      vecs[9]  = mk(0, 0, 8'h00, 0, 1, 3, pk(1, 1, 1, 8'h20, 1, 1, 8'h20, 8'h40, 2));
      vecs[10] = mk(0, 0, 8'h00, 0, 1, 3, pk(1, 1, 2, 8'h30, 0, 1, 8'h00, 8'h40, 1));
      vecs[11] = mk(0, 0, 8'h00, 0, 1, 3, pk(1, 1, 3, 8'h40, 0, 1, 8'h00, 8'h40, 0));
      vecs[12] = mk(0, 0, 8'h00, 0, 1, 3, pk(1, 0, 3, 8'h40, 0, 0, 8'h00, 8'h00, 0));
      vecs[13] = mk(1, 1, 8'h11, 1, 1, 3, pk(1, 0, 3, 8'h40, 1, 0, 8'h11, 8'h00, 1));
      vecs[14] = mk(1, 1, 8'h22, 1, 1, 3, pk(1, 0, 3, 8'h40, 1, 0, 8'h22, 8'h00, 2));
      vecs[15] = mk(0, 0, 8'h00, 0, 1, 3, pk(1, 1, 1, 8'h11, 1, 0, 8'h22, 8'h00, 1));
      vecs[16] = mk(1, 3, 8'h33, 0, 1, 3, pk(1, 1, 1, 8'h22, 1, 1, 8'h22, 8'h33, 1));
      vecs[17] = mk(0, 0, 8'h00, 0, 1, 3, pk(1, 1, 3, 8'h33, 0, 1, 8'h00, 8'h33, 0));
      vecs[18] = mk(0, 0, 8'h00, 0, 1, 3, pk(1, 0, 3, 8'h33, 0, 0, 8'h00, 8'h00, 0));
      drive(0, 0, 0, 0, 0, 1);
      repeat (2) @(negedge clk);
      chk("reset_state", outs(), pk(1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0));
      rst_n = 1'b1;
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         drive(vecs[i].v, vecs[i].r, vecs[i].d, vecs[i].h, vecs[i].l1, vecs[i].l2);
         @(posedge clk);
         #1 chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
      end
      // streaming across pointer wrap with periodic hold
      sent = 0;
      got = 0;
      for (int c = 0; c < 100 && got < 10; c++) begin
         @(negedge clk);
         drive(sent < 10, 2'(sent % 4), 8'(sent), c % 3 == 2, 0, 0);
         #1 acc = bus.in_valid && bus.in_ready;
         @(posedge clk);
         #1 if (acc) sent++;
         if (bus.write_reg_en) begin
            chk($sformatf("stream%0d", got), {23'd0, bus.write_reg, bus.write_data},
                {23'd0, 2'(got % 4), 8'(got)});
            got++;
         end
      end
      chk("stream_total", {1'b0, 32'(got)}, 33'd10);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1 chk("stream_drained", {30'd0, bus.count}, 33'd0);
      chk("stream_no_extra", {32'd0, bus.write_reg_en}, 33'd0);
      // reset in the middle of activity
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(1, 2'(i), 8'hA0 + 8'(i), 1, 1, 2);
         @(posedge clk);
      end
      @(negedge clk);
      drive(0, 0, 0, 0, 1, 2);
      @(posedge clk);
      #1 chk("pre_reset", outs(), pk(1, 1, 0, 8'hA0, 1, 1, 8'hA1, 8'hA2, 3));
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 chk("async_reset", outs(), pk(1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0));
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 chk($sformatf("post_reset%0d", i), outs(), pk(1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0));
      end
      @(negedge clk);
      drive(1, 2, 8'h77, 0, 2, 1);
      @(posedge clk);
      #1 chk("post_reset_push", outs(), pk(1, 0, 0, 8'h00, 1, 0, 8'h77, 8'h00, 1));
      @(negedge clk);
      drive(0, 0, 0, 0, 2, 1);
      @(posedge clk);
      #1 chk("post_reset_pop", outs(), pk(1, 1, 2, 8'h77, 1, 0, 8'h77, 8'h00, 0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
